ov5640_sccb_wr: RTL and testbench

- SCCB/I2C write master for the OV5640. It is the consumer side of the per-register config handshake.
- Accepts one 24-bit word per cfg_start pulse: {16-bit register address, 8-bit value}.
- Serialises that word as a 4-byte SCCB write: device address+W, address high byte, address low byte, data.
- Returns a one-cycle cfg_end after STOP plus bus-free time, so the table sequencer can issue the next register.

---
 rtl/ov5640_sccb_wr.sv | 146 ++++++++++++++
 tb/tb_ov5640_sccb_wr.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov5640_sccb_wr.sv
// SCCB write master for the OV5640: sends {addr+W, reg[15:8], reg[7:0], value}
// for each accepted cfg_start and pulses cfg_end once STOP and bus-free time have elapsed.
module ov5640_sccb_wr #(
  parameter int         SYS_CLK_FREQ = 50_000_000,
  parameter int         SCL_FREQ     = 250_000,
  parameter logic [6:0] DEVICE_ADDR  = 7'h3C
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        cfg_start,
  input  logic [23:0] cfg_data,
  output logic        cfg_end,
  output logic        busy,
  output logic        ack_err,
  output logic        scl,
  inout  wire         sda
);

  localparam int QTR = SYS_CLK_FREQ / (4 * SCL_FREQ);
  localparam int QW  = (QTR > 1) ? $clog2(QTR) : 1;

  typedef enum logic [2:0] {IDLE, START, BIT, STOP, BUF, DONE} state_t;

  state_t        state;
  logic [QW-1:0] qcnt;
  logic [1:0]    phase;
  logic [3:0]    bit_cnt;
  logic [1:0]    byte_cnt;
  logic [31:0]   shreg;
  logic          sda_oe;
  logic          tick;

  // The quarter counter only runs while a transfer is on the wire.
  assign tick = (state != IDLE) && (state != DONE) && (qcnt == QW'(QTR - 1));

  // Open-drain: only ever pull low; a 1 comes from the external pull-up.
  assign sda = sda_oe ? 1'b0 : 1'bz;

  // NOTE: every register here is sequential state, so all assignments are
  // non-blocking; blocking ones would make later lines see same-cycle values.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      qcnt     <= '0;
      phase    <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      shreg    <= '0;
      sda_oe   <= 1'b0;
      scl      <= 1'b1;
      cfg_end  <= 1'b0;
      busy     <= 1'b0;
      ack_err  <= 1'b0;
    end else begin
      cfg_end <= 1'b0;

      if (state == IDLE || state == DONE || tick) qcnt <= '0;
      else                                        qcnt <= qcnt + 1'b1;

      if (tick) phase <= phase + 1'b1;

      // Outputs are set on the tick that enters the quarter they belong to.
      case (state)
        IDLE: begin
          if (cfg_start) begin
            shreg   <= {DEVICE_ADDR, 1'b0, cfg_data};
            ack_err <= 1'b0;
            busy    <= 1'b1;
            state   <= START;
          end
        end

        START: begin
          if (tick) begin
            case (phase)
              2'd1: sda_oe <= 1'b1;
              2'd2: scl    <= 1'b0;
              2'd3: begin
                state  <= BIT;
                sda_oe <= ~shreg[31];
              end
              default: ;
            endcase
          end
        end

        BIT: begin
          if (tick) begin
            case (phase)
              2'd0: scl <= 1'b1;
              2'd2: begin
                scl <= 1'b0;
                // A NACK is only recorded; SCCB treats the ACK bit as don't-care.
                if (bit_cnt == 4'd8 && sda) ack_err <= 1'b1;
              end
              2'd3: begin
                if (bit_cnt == 4'd8) begin
                  bit_cnt <= '0;
                  if (byte_cnt == 2'd3) begin
                    byte_cnt <= '0;
                    state    <= STOP;
                    sda_oe   <= 1'b1;
                  end else begin
                    byte_cnt <= byte_cnt + 1'b1;
                    sda_oe   <= ~shreg[31];
                  end
                end else begin
                  bit_cnt <= bit_cnt + 1'b1;
                  shreg   <= {shreg[30:0], 1'b0};
                  sda_oe  <= (bit_cnt == 4'd7) ? 1'b0 : ~shreg[30];
                end
              end
              default: ;
            endcase
          end
        end

        STOP: begin
          if (tick) begin
            case (phase)
              2'd0: scl    <= 1'b1;
              2'd1: sda_oe <= 1'b0;
              2'd3: state  <= BUF;
              default: ;
            endcase
          end
        end

        BUF: begin
          if (tick && phase == 2'd3) begin
            state   <= DONE;
            cfg_end <= 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ov5640_sccb_wr.sv
// Directed bench for ov5640_sccb_wr: an SCCB slave model decodes the wire and
// drives ACKs; each task checks one feature against hand-computed values.
module tb_ov5640_sccb_wr;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic [23:0] cfg_data = '0;
  logic        cfg_end, busy, ack_err, scl;
  wire         sda_bus;
  logic        slave_drv = 1'b0;

  logic        cfg_start2 = 1'b0;
  logic [23:0] cfg_data2 = '0;
  logic        cfg_end2, busy2, ack_err2, scl2;
  wire         sda2;

  pullup (sda_bus);
  pullup (sda2);
  assign sda_bus = slave_drv ? 1'b0 : 1'bz;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  ov5640_sccb_wr dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .cfg_start (cfg_start),
    .cfg_data  (cfg_data),
    .cfg_end   (cfg_end),
    .busy      (busy),
    .ack_err   (ack_err),
    .scl       (scl),
    .sda       (sda_bus)
  );

  ov5640_sccb_wr #(.SYS_CLK_FREQ(50_000_000), .SCL_FREQ(100_000)) dut_slow (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .cfg_start (cfg_start2),
    .cfg_data  (cfg_data2),
    .cfg_end   (cfg_end2),
    .busy      (busy2),
    .ack_err   (ack_err2),
    .scl       (scl2),
    .sda       (sda2)
  );

  // Slave model / wire decoder, sampled on the falling sys_clk edge.
  logic [7:0] rx_q[$];
  int n_start = 0;
  int n_stop = 0;
  int n_end = 0;
  int nack_byte = -1;
  int min_idle = 1000000;

  initial begin : monitor
    logic       ps, pd, in_ack;
    logic [7:0] cur;
    int         bitc, byte_idx, idle;
    ps = 1'b1; pd = 1'b1; in_ack = 1'b0; cur = '0;
    bitc = 0; byte_idx = 0; idle = 0;
    forever begin
      @(negedge sys_clk);
      if (cfg_end === 1'b1) n_end++;
      if (scl && ps && pd && sda_bus === 1'b0) begin
        n_start++;
        if (idle < min_idle) min_idle = idle;
        bitc = 0; byte_idx = 0; in_ack = 1'b0; slave_drv = 1'b0;
      end else if (scl && ps && !pd && sda_bus === 1'b1) begin
        n_stop++;
      end else if (scl && !ps) begin
        if (!in_ack && bitc < 8) begin
          cur = {cur[6:0], sda_bus};
          bitc++;
          if (bitc == 8) rx_q.push_back(cur);
        end
      end else if (!scl && ps) begin
        if (in_ack) begin
          in_ack = 1'b0; slave_drv = 1'b0; bitc = 0;
        end else if (bitc == 8) begin
          in_ack = 1'b1;
          slave_drv = (byte_idx != nack_byte);
          byte_idx++;
        end
      end
      idle = (scl && sda_bus === 1'b1) ? idle + 1 : 0;
      ps = scl; pd = sda_bus;
    end
  end

  function automatic logic [31:0] rx_word(input int base);
    if (rx_q.size() < base + 4) return 32'hxxxx_xxxx;
    return {rx_q[base], rx_q[base+1], rx_q[base+2], rx_q[base+3]};
  endfunction

  task automatic do_write(input logic [23:0] d, output int acc);
    @(negedge sys_clk);
    cfg_data  = d;
    cfg_start = 1'b1;
    @(posedge sys_clk); #1;
    acc = cyc;
    cfg_start = 1'b0;
  endtask

  task automatic wait_end(input int acc, output int lat);
    while (cfg_end !== 1'b1 && cyc - acc < 30000) begin
      @(posedge sys_clk); #1;
    end
    lat = cyc - acc;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge sys_clk);
    checks++; if (scl !== 1'b1) begin errors++; $display("FAIL reset_scl: got %b expected 1", scl); end
    checks++; if (sda_bus !== 1'b1) begin errors++; $display("FAIL reset_sda: got %b expected 1 (released)", sda_bus); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (cfg_end !== 1'b0) begin errors++; $display("FAIL reset_cfg_end: got %b expected 0", cfg_end); end
    checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL reset_ack_err: got %b expected 0", ack_err); end
    sys_rst_n = 1'b1;
    repeat (5) @(negedge sys_clk);
  endtask

  task automatic test_single;
    int acc, lat, ns;
    rx_q.delete(); n_start = 0; n_stop = 0; ns = n_end;
    do_write(24'h310311, acc);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_accept: got %b expected 1", busy); end
    wait_end(acc, lat);
    checks++; if (lat != 7800) begin errors++; $display("FAIL single_latency: got %0d expected 7800", lat); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_at_end: got %b expected 1", busy); end
    checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL single_ack_err: got %b expected 0", ack_err); end
    @(posedge sys_clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b expected 0", busy); end
    checks++; if (cfg_end !== 1'b0) begin errors++; $display("FAIL single_end_width: got %b expected 0", cfg_end); end
    checks++; if (rx_word(0) !== 32'h78310311) begin errors++; $display("FAIL single_bytes: got %h expected 78310311", rx_word(0)); end
    checks++; if (n_start != 1 || n_stop != 1) begin errors++; $display("FAIL single_start_stop: got %0d/%0d expected 1/1", n_start, n_stop); end
    checks++; if (n_end - ns != 1) begin errors++; $display("FAIL single_end_count: got %0d expected 1", n_end - ns); end
  endtask

  task automatic test_nack;
    int acc, lat;
    rx_q.delete(); n_stop = 0; nack_byte = 1;
    do_write(24'h300882, acc);
    wait_end(acc, lat);
    checks++; if (lat != 7800) begin errors++; $display("FAIL nack_latency: got %0d expected 7800", lat); end
    checks++; if (ack_err !== 1'b1) begin errors++; $display("FAIL nack_ack_err: got %b expected 1", ack_err); end
    @(posedge sys_clk); #1;
    checks++; if (rx_word(0) !== 32'h78300882) begin errors++; $display("FAIL nack_bytes: got %h expected 78300882", rx_word(0)); end
    checks++; if (n_stop != 1) begin errors++; $display("FAIL nack_stop: got %0d expected 1", n_stop); end
    nack_byte = -1;
  endtask

  task automatic test_busy_ignore;
    int acc, lat, ns;
    rx_q.delete(); ns = n_end;
    do_write(24'h3017FF, acc);
    checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL busy_ack_err_cleared: got %b expected 0", ack_err); end
    repeat (99) @(posedge sys_clk);
    @(negedge sys_clk);
    cfg_data = 24'hFFFFFF; cfg_start = 1'b1;
    @(negedge sys_clk);
    cfg_start = 1'b0;
    wait_end(acc, lat);
    checks++; if (lat != 7800) begin errors++; $display("FAIL busy_latency: got %0d expected 7800", lat); end
    checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL busy_ack_err: got %b expected 0", ack_err); end
    repeat (300) @(posedge sys_clk);
    #1;
    checks++; if (rx_q.size() != 4 || rx_word(0) !== 32'h783017FF) begin errors++; $display("FAIL busy_bytes: got %h (n=%0d) expected 783017FF (n=4)", rx_word(0), rx_q.size()); end
    checks++; if (n_end - ns != 1) begin errors++; $display("FAIL busy_end_count: got %0d expected 1", n_end - ns); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_idle: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid;
    int acc, lat, ns;
    ns = n_end;
    do_write(24'h300882, acc);
    repeat (4410) @(posedge sys_clk);
    #3;
    sys_rst_n = 1'b0;
    #1;
    checks++; if (scl !== 1'b1) begin errors++; $display("FAIL rst_mid_scl: got %b expected 1", scl); end
    checks++; if (sda_bus !== 1'b1) begin errors++; $display("FAIL rst_mid_sda: got %b expected 1 (released)", sda_bus); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (4000) @(negedge sys_clk);
    checks++; if (n_end != ns) begin errors++; $display("FAIL rst_mid_no_end: got %0d expected 0", n_end - ns); end
    rx_q.delete();
    do_write(24'h310303, acc);
    wait_end(acc, lat);
    checks++; if (lat != 7800) begin errors++; $display("FAIL rst_mid_latency: got %0d expected 7800", lat); end
    @(posedge sys_clk); #1;
    checks++; if (rx_word(0) !== 32'h78310303) begin errors++; $display("FAIL rst_mid_bytes: got %h expected 78310303", rx_word(0)); end
    checks++; if (n_end - ns != 1) begin errors++; $display("FAIL rst_mid_end_count: got %0d expected 1", n_end - ns); end
  endtask

  task automatic test_back_to_back;
    logic [23:0] words [3];
    int acc, lat;
    words[0] = 24'h310311; words[1] = 24'h300882; words[2] = 24'h300842;
    rx_q.delete(); n_start = 0; min_idle = 1000000;
    do_write(words[0], acc);
    for (int k = 0; k < 3; k++) begin
      wait_end(acc, lat);
      checks++; if (lat != 7800) begin errors++; $display("FAIL b2b_latency_%0d: got %0d expected 7800", k, lat); end
      if (k < 2) begin
        cfg_data = words[k+1]; cfg_start = 1'b1;
        @(posedge sys_clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_start_in_done_%0d: got busy %b expected 0", k, busy); end
        @(posedge sys_clk); #1;
        acc = cyc; cfg_start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept_%0d: got busy %b expected 1", k, busy); end
      end
    end
    @(posedge sys_clk); #1;
    checks++; if (rx_word(0) !== 32'h78310311) begin errors++; $display("FAIL b2b_bytes_0: got %h expected 78310311", rx_word(0)); end
    checks++; if (rx_word(4) !== 32'h78300882) begin errors++; $display("FAIL b2b_bytes_1: got %h expected 78300882", rx_word(4)); end
    checks++; if (rx_word(8) !== 32'h78300842) begin errors++; $display("FAIL b2b_bytes_2: got %h expected 78300842", rx_word(8)); end
    checks++; if (n_start != 3) begin errors++; $display("FAIL b2b_starts: got %0d expected 3", n_start); end
    checks++; if (min_idle < 200) begin errors++; $display("FAIL b2b_bus_free: got %0d expected >= 200", min_idle); end
  endtask

  task automatic test_override;
    int acc, r1, r2, lat;
    @(negedge sys_clk);
    cfg_data2 = 24'h310311; cfg_start2 = 1'b1;
    @(posedge sys_clk); #1;
    acc = cyc; cfg_start2 = 1'b0;
    while (scl2 !== 1'b0 && cyc - acc < 2000) begin @(posedge sys_clk); #1; end
    while (scl2 !== 1'b1 && cyc - acc < 2000) begin @(posedge sys_clk); #1; end
    r1 = cyc;
    while (scl2 !== 1'b0 && cyc - acc < 3000) begin @(posedge sys_clk); #1; end
    while (scl2 !== 1'b1 && cyc - acc < 3000) begin @(posedge sys_clk); #1; end
    r2 = cyc;
    checks++; if (r2 - r1 != 500) begin errors++; $display("FAIL override_scl_period: got %0d expected 500", r2 - r1); end
    while (cfg_end2 !== 1'b1 && cyc - acc < 30000) begin @(posedge sys_clk); #1; end
    lat = cyc - acc;
    checks++; if (lat != 19500) begin errors++; $display("FAIL override_latency: got %0d expected 19500", lat); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_nack();
    test_busy_ignore();
    test_reset_mid();
    fork
      test_back_to_back();
      test_override();
    join
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
